// File: rtl/apu_envelope.sv
// apu_envelope: per-channel decay envelope and length counter.
// Quarter-frame strobes step the envelope, half-frame strobes step the length
// counter. Volume and active are registered from the current state, so they
// trail any state change by one clock.
module apu_envelope (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable_240hz,
   input  logic       enable_120hz,
   input  logic       channel_en,
   input  logic       wr_ctrl,
   input  logic       wr_length,
   input  logic [7:0] wr_data,
   output logic [3:0] volume,
   output logic       active
);

   logic       loop_q,      loop_d;
   logic       const_vol_q, const_vol_d;
   logic [3:0] period_q,    period_d;
   logic       start_q,     start_d;
   logic [3:0] divider_q,   divider_d;
   logic [3:0] decay_q,     decay_d;
   logic [7:0] length_q,    length_d;
   logic [3:0] volume_q,    volume_d;
   logic       active_q,    active_d;

   // Length load table, indexed by wr_data[7:3]
   function automatic logic [7:0] length_lut(input logic [4:0] idx);
      logic [7:0] val;
      case (idx)
         5'd0:    val = 8'd10;
         5'd1:    val = 8'd254;
         5'd2:    val = 8'd20;
         5'd3:    val = 8'd2;
         5'd4:    val = 8'd40;
         5'd5:    val = 8'd4;
         5'd6:    val = 8'd80;
         5'd7:    val = 8'd6;
         5'd8:    val = 8'd160;
         5'd9:    val = 8'd8;
         5'd10:   val = 8'd60;
         5'd11:   val = 8'd10;
         5'd12:   val = 8'd14;
         5'd13:   val = 8'd12;
         5'd14:   val = 8'd26;
         5'd15:   val = 8'd14;
         5'd16:   val = 8'd12;
         5'd17:   val = 8'd16;
         5'd18:   val = 8'd24;
         5'd19:   val = 8'd18;
         5'd20:   val = 8'd48;
         5'd21:   val = 8'd20;
         5'd22:   val = 8'd96;
         5'd23:   val = 8'd22;
         5'd24:   val = 8'd192;
         5'd25:   val = 8'd24;
         5'd26:   val = 8'd72;
         5'd27:   val = 8'd26;
         5'd28:   val = 8'd16;
         5'd29:   val = 8'd28;
         5'd30:   val = 8'd32;
         5'd31:   val = 8'd30;
         default: val = 8'd0;
      endcase
      return val;
   endfunction

   // Next-state logic: envelope tick, register writes, length counter, outputs
   always_comb begin
      loop_d      = loop_q;
      const_vol_d = const_vol_q;
      period_d    = period_q;
      start_d     = start_q;
      divider_d   = divider_q;
      decay_d     = decay_q;
      length_d    = length_q;
      volume_d    = volume_q;
      active_d    = active_q;

      // Envelope step uses pre-write loop/period and the old start flag
      if (enable_240hz) begin
         if (start_q) begin
            start_d   = 1'b0;
            decay_d   = 4'd15;
            divider_d = period_q;
         end else if (divider_q == 4'd0) begin
            divider_d = period_q;
            if (decay_q != 4'd0) begin
               decay_d = decay_q - 4'd1;
            end else if (loop_q) begin
               decay_d = 4'd15;
            end else begin
               decay_d = decay_q;
            end
         end else begin
            divider_d = divider_q - 4'd1;
         end
      end else begin
         divider_d = divider_q;
      end

      // A length write arms a restart for the next quarter frame
      if (wr_length) begin
         start_d = 1'b1;
      end else begin
         start_d = start_d;
      end

      if (wr_ctrl) begin
         loop_d      = wr_data[5];
         const_vol_d = wr_data[4];
         period_d    = wr_data[3:0];
      end else begin
         loop_d      = loop_q;
      end

      // Disable beats load, load beats decrement, loop doubles as halt
      if (!channel_en) begin
         length_d = 8'd0;
      end else if (wr_length) begin
         length_d = length_lut(wr_data[7:3]);
      end else if (enable_120hz && (length_q != 8'd0) && !loop_q) begin
         length_d = length_q - 8'd1;
      end else begin
         length_d = length_q;
      end

      if (length_q == 8'd0) begin
         volume_d = 4'd0;
      end else if (const_vol_q) begin
         volume_d = period_q;
      end else begin
         volume_d = decay_q;
      end
      active_d = (length_q != 8'd0);
   end

   // State and output registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         loop_q      <= 1'b0;
         const_vol_q <= 1'b0;
         period_q    <= 4'd0;
         start_q     <= 1'b0;
         divider_q   <= 4'd0;
         decay_q     <= 4'd0;
         length_q    <= 8'd0;
         volume_q    <= 4'd0;
         active_q    <= 1'b0;
      end else begin
         loop_q      <= loop_d;
         const_vol_q <= const_vol_d;
         period_q    <= period_d;
         start_q     <= start_d;
         divider_q   <= divider_d;
         decay_q     <= decay_d;
         length_q    <= length_d;
         volume_q    <= volume_d;
         active_q    <= active_d;
      end
   end

   assign volume = volume_q;
   assign active = active_q;

endmodule

// File: tb/tb_apu_envelope.sv
// Self-checking bench for apu_envelope: a behavioural model pushes the
// expected outputs per clock into a scoreboard queue; each scenario pops and
// compares them, and adds fixed-value checks taken from the intended behaviour.
module tb_apu_envelope;

   logic       clk;
   logic       rst_n;
   logic       enable_240hz;
   logic       enable_120hz;
   logic       channel_en;
   logic       wr_ctrl;
   logic       wr_length;
   logic [7:0] wr_data;
   logic [3:0] volume;
   logic       active;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [3:0] vol;
      logic       act;
   } exp_t;

   exp_t sb_q[$];

   int unsigned lut [0:31] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                               12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};

   // reference model state
   logic       m_loop, m_const, m_start;
   logic [3:0] m_period, m_div, m_decay;
   logic [7:0] m_len;

   apu_envelope dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable_240hz (enable_240hz),
      .enable_120hz (enable_120hz),
      .channel_en   (channel_en),
      .wr_ctrl      (wr_ctrl),
      .wr_length    (wr_length),
      .wr_data      (wr_data),
      .volume       (volume),
      .active       (active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_loop = 1'b0; m_const = 1'b0; m_start = 1'b0;
      m_period = 4'd0; m_div = 4'd0; m_decay = 4'd0; m_len = 8'd0;
      sb_q.delete();
   endtask

   task automatic model_edge(input logic e240, input logic e120, input logic en,
                             input logic wc, input logic wl, input logic [7:0] d);
      logic [3:0] p;
      logic       lp;
      logic       st;
      p  = m_period;
      lp = m_loop;
      st = m_start;
      if (e240) begin
         if (st) begin
            m_decay = 4'd15;
            m_div   = p;
            m_start = 1'b0;
         end else if (m_div == 4'd0) begin
            m_div = p;
            if (m_decay != 4'd0) m_decay = m_decay - 4'd1;
            else if (lp) m_decay = 4'd15;
         end else begin
            m_div = m_div - 4'd1;
         end
      end
      if (wl) m_start = 1'b1;
      if (!en) m_len = 8'd0;
      else if (wl) m_len = 8'(lut[d[7:3]]);
      else if (e120 && m_len != 8'd0 && !lp) m_len = m_len - 8'd1;
      if (wc) begin
         m_loop   = d[5];
         m_const  = d[4];
         m_period = d[3:0];
      end
   endtask

   // one clock: push the outputs the DUT must show after this edge, then advance the model
   task automatic step(input logic e240, input logic e120, input logic wc,
                       input logic wl, input logic [7:0] d);
      exp_t e;
      enable_240hz = e240;
      enable_120hz = e120;
      wr_ctrl      = wc;
      wr_length    = wl;
      wr_data      = d;
      e.act = (m_len != 8'd0);
      e.vol = (m_len == 8'd0) ? 4'd0 : (m_const ? m_period : m_decay);
      sb_q.push_back(e);
      @(posedge clk);
      model_edge(e240, e120, channel_en, wc, wl, d);
      #1;
      enable_240hz = 1'b0;
      enable_120hz = 1'b0;
      wr_ctrl      = 1'b0;
      wr_length    = 1'b0;
   endtask

   function automatic exp_t sb_pop();
      exp_t e;
      e.vol = 4'hx;
      e.act = 1'bx;
      if (sb_q.size() != 0) e = sb_q.pop_front();
      return e;
   endfunction

   task automatic test_reset();
      exp_t e;
      rst_n = 1'b0;
      #12;
      checks++;
      if (volume !== 4'd0 || active !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: volume=%0d active=%0b expected volume=0 active=0", volume, active);
      end
      model_reset();
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) begin
         logic r120, r240;
         r120 = 1'($urandom_range(0, 1));
         r240 = r120 | 1'($urandom_range(0, 1));
         step(r240, r120, 1'b0, 1'b0, 8'h00);
         e = sb_pop();
         checks++;
         if (volume !== e.vol || active !== e.act || volume !== 4'd0 || active !== 1'b0) begin
            errors++;
            $display("FAIL idle_cycle%0d: volume=%0d active=%0b expected volume=0 active=0", i, volume, active);
         end
      end
   endtask

   task automatic test_const_volume();
      exp_t e;
      channel_en = 1'b1;
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'h3A);
      e = sb_pop();
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'h08);
      e = sb_pop();
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      e = sb_pop();
      checks++;
      if (volume !== 4'd10 || active !== 1'b1 || volume !== e.vol || active !== e.act) begin
         errors++;
         $display("FAIL const_first: volume=%0d active=%0b expected volume=10 active=1", volume, active);
      end
      for (int i = 0; i < 300; i++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
         e = sb_pop();
         step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
         e = sb_pop();
         checks++;
         if (volume !== 4'd10 || active !== 1'b1 || volume !== e.vol || active !== e.act) begin
            errors++;
            $display("FAIL const_hold_tick%0d: volume=%0d active=%0b expected volume=10 active=1", i, volume, active);
         end
      end
   endtask

   // ctrl=0x02 decays to 0 and holds; ctrl=0x22 reloads 15 at the next expiry
   task automatic test_decay(input logic [7:0] ctrl, input logic looped);
      exp_t e;
      int   zero_tick;
      int   reload_tick;
      zero_tick   = 0;
      reload_tick = 0;
      step(1'b0, 1'b0, 1'b1, 1'b0, ctrl);
      e = sb_pop();
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'h08);
      e = sb_pop();
      for (int t = 1; t <= 60; t++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
         e = sb_pop();
         step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
         e = sb_pop();
         checks++;
         if (volume !== e.vol || active !== e.act) begin
            errors++;
            $display("FAIL decay_ctrl%02h_tick%0d: volume=%0d active=%0b expected volume=%0d active=%0b",
                     ctrl, t, volume, active, e.vol, e.act);
         end
         if (t == 1) begin
            checks++;
            if (volume !== 4'd15) begin
               errors++;
               $display("FAIL decay_restart: volume=%0d expected 15", volume);
            end
         end
         if (volume == 4'd0 && zero_tick == 0) zero_tick = t;
         if (zero_tick != 0 && volume == 4'd15 && reload_tick == 0) reload_tick = t;
      end
      checks++;
      if (zero_tick != 46) begin
         errors++;
         $display("FAIL decay_zero_tick: reached 0 at tick %0d expected 46", zero_tick);
      end
      checks++;
      if (looped && reload_tick != 49) begin
         errors++;
         $display("FAIL loop_reload_tick: reload at tick %0d expected 49", reload_tick);
      end else if (!looped && reload_tick != 0) begin
         errors++;
         $display("FAIL decay_hold: reload at tick %0d expected none", reload_tick);
      end
   endtask

   task automatic test_length_expiry();
      exp_t e;
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'h1F);
      e = sb_pop();
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'h18);
      e = sb_pop();
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      e = sb_pop();
      for (int k = 1; k <= 2; k++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
         e = sb_pop();
         checks++;
         if (volume !== 4'd15 || active !== 1'b1 || volume !== e.vol || active !== e.act) begin
            errors++;
            $display("FAIL length_tick%0d: volume=%0d active=%0b expected volume=15 active=1", k, volume, active);
         end
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      e = sb_pop();
      checks++;
      if (volume !== 4'd0 || active !== 1'b0 || volume !== e.vol || active !== e.act) begin
         errors++;
         $display("FAIL length_expired: volume=%0d active=%0b expected volume=0 active=0", volume, active);
      end
   endtask

   task automatic test_enable_collision();
      exp_t e;
      channel_en = 1'b0;
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'h08);
      e = sb_pop();
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
         e = sb_pop();
         checks++;
         if (active !== 1'b0 || active !== e.act) begin
            errors++;
            $display("FAIL disabled_load%0d: active=%0b expected 0", i, active);
         end
      end
      channel_en = 1'b1;
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'h10);
      e = sb_pop();
      // load of 2 coincident with a half-frame tick: must stay 2
      step(1'b1, 1'b1, 1'b0, 1'b1, 8'h18);
      e = sb_pop();
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      e = sb_pop();
      for (int k = 1; k <= 2; k++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
         e = sb_pop();
         step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
         e = sb_pop();
         checks++;
         if (active !== (k == 1) || active !== e.act || volume !== e.vol) begin
            errors++;
            $display("FAIL collision_tick%0d: active=%0b volume=%0d expected active=%0b volume=%0d",
                     k, active, volume, (k == 1), e.vol);
         end
      end
      // dropping channel_en mid-count clears the length
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'h08);
      e = sb_pop();
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      e = sb_pop();
      channel_en = 1'b0;
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      e = sb_pop();
      checks++;
      if (active !== 1'b1 || active !== e.act) begin
         errors++;
         $display("FAIL enable_before_drop: active=%0b expected 1", active);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      e = sb_pop();
      checks++;
      if (active !== 1'b0 || volume !== 4'd0 || active !== e.act) begin
         errors++;
         $display("FAIL enable_drop: active=%0b volume=%0d expected active=0 volume=0", active, volume);
      end
   endtask

   task automatic test_midop_reset();
      exp_t e;
      channel_en = 1'b1;
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'h37);
      e = sb_pop();
      step(1'b0, 1'b0, 1'b0, 1'b1, 8'h08);
      e = sb_pop();
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      e = sb_pop();
      checks++;
      if (active !== 1'b1 || volume !== 4'd7) begin
         errors++;
         $display("FAIL midop_pre: active=%0b volume=%0d expected active=1 volume=7", active, volume);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (active !== 1'b0 || volume !== 4'd0) begin
         errors++;
         $display("FAIL midop_async_clear: active=%0b volume=%0d expected active=0 volume=0", active, volume);
      end
      model_reset();
      #10;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
         e = sb_pop();
         checks++;
         if (active !== 1'b0 || volume !== 4'd0 || active !== e.act || volume !== e.vol) begin
            errors++;
            $display("FAIL midop_idle%0d: active=%0b volume=%0d expected active=0 volume=0", i, active, volume);
         end
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      enable_240hz = 1'b0;
      enable_120hz = 1'b0;
      channel_en   = 1'b0;
      wr_ctrl      = 1'b0;
      wr_length    = 1'b0;
      wr_data      = 8'h00;
      model_reset();
      test_reset();
      test_const_volume();
      test_decay(8'h02, 1'b0);
      test_decay(8'h22, 1'b1);
      test_length_expiry();
      test_enable_collision();
      test_midop_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
